axis_uart_rx: RTL and testbench

UART receiver that deserialises 8N1 frames from an asynchronous serial line and presents each byte as a single-beat AXI-Stream master transfer. Sits directly upstream of the byte-wide stream processor (`s_axis_*` side, `INP_WIDTH = 8`) and feeds it host bytes. Holds one received byte; backpressure beyond that is reported as overrun, never stalls the line.

---
 rtl/axis_uart_rx.sv | 206 ++++++++++++++++++++
 tb/tb_axis_uart_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_uart_rx.sv
// UART 8N1 receiver presenting each byte as a single-beat AXI-Stream transfer.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive err_parity.
module axis_uart_rx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       rx,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       err_frame,
  output logic       err_overrun,
  output logic       err_parity
);

  localparam int DIV = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_BIT  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  generate
    if (DIV < 4) begin : g_div_check
      $error("axis_uart_rx: clocks per bit must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3
`ifdef UART_RX_PARITY_EN
    , ST_PARITY = 3'd4
`endif
  } state_t;

  logic [1:0]    sync_q;
  logic          rx_s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d;
  logic          err_frame_q, err_frame_d;
  logic          err_overrun_q, err_overrun_d;
  logic          tick_s;
`ifdef UART_RX_PARITY_EN
  logic          par_err_q, par_err_d;
  logic          err_parity_q, err_parity_d;
`endif

  assign rx_s   = sync_q[1];
  assign tick_s = (cnt_q == CNT_ZERO);

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  // Frame sequencing, sampling and output-register next state
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    tdata_d       = tdata_q;
    err_frame_d   = 1'b0;
    err_overrun_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d     = par_err_q;
    err_parity_d  = 1'b0;
`endif
    if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end else begin
      tvalid_d = tvalid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          cnt_d   = CNT_HALF;
          state_d = ST_START;
`ifdef UART_RX_PARITY_EN
          par_err_d = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (!tick_s) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d     = CNT_BIT;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!tick_s) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = CNT_BIT;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (!tick_s) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          par_err_d = rx_s ^ (^shift_q);
          cnt_d     = CNT_BIT;
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (!tick_s) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          // Leave mid-stop-bit so a back-to-back start edge is not missed
          state_d = ST_IDLE;
          if (!rx_s) begin
            err_frame_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_err_q) begin
            err_parity_d = 1'b1;
`endif
          end else if (!tvalid_q || m_axis_tready) begin
            tdata_d  = shift_q;
            tvalid_d = 1'b1;
          end else begin
            err_overrun_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= CNT_ZERO;
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'h00;
      tdata_q       <= 8'h00;
      tvalid_q      <= 1'b0;
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q     <= 1'b0;
      err_parity_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      err_frame_q   <= err_frame_d;
      err_overrun_q <= err_overrun_d;
`ifdef UART_RX_PARITY_EN
      par_err_q     <= par_err_d;
      err_parity_q  <= err_parity_d;
`endif
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign err_frame     = err_frame_q;
  assign err_overrun   = err_overrun_q;
`ifdef UART_RX_PARITY_EN
  assign err_parity    = err_parity_q;
`else
  assign err_parity    = 1'b0;
`endif

endmodule

// File: tb/tb_axis_uart_rx.sv
// Self-checking bench for axis_uart_rx: vector table plus scoreboard of expected bytes.
module tb_axis_uart_rx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = 10;

  logic       clk = 1'b0;
  logic       arst;
  logic       rx;
  logic       tready;
  logic [7:0] tdata;
  logic       tvalid;
  logic       err_frame, err_overrun, err_parity;

  always #5 clk = ~clk;

  axis_uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
    .clk(clk), .arst(arst), .rx(rx),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .err_frame(err_frame), .err_overrun(err_overrun), .err_parity(err_parity)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop_b;
    logic       par_flip;
    logic       exp_beat;
    int         exp_frame;
    int         exp_par;
  } vec_t;

  int cmp_cnt = 0, mis_cnt = 0;
  int cyc = 0, fall_cyc = 0, rise_cyc = 0;
  int n_beat = 0, n_frame = 0, n_over = 0, n_par = 0, n_valid = 0;
  logic [7:0] exp_q[$];
  vec_t vecs[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic       p_tvalid = 1'b0, p_tready = 1'b0, p_ef = 1'b0, p_eo = 1'b0, p_ep = 1'b0;
  logic [7:0] p_tdata = 8'h00;

  // Output monitor: scoreboard pops, pulse widths, data stability
  always @(negedge clk) begin
    if (arst) begin
      p_tvalid = 1'b0; p_tready = 1'b0; p_ef = 1'b0; p_eo = 1'b0; p_ep = 1'b0;
    end else begin
      if (tvalid && !p_tvalid) rise_cyc = cyc;
      if (p_tvalid && !p_tready) check("tdata_stable", {24'h0, tdata}, {24'h0, p_tdata});
      if (p_ef) check("err_frame_width", {31'h0, err_frame}, 32'h0);
      if (p_eo) check("err_overrun_width", {31'h0, err_overrun}, 32'h0);
      if (p_ep) check("err_parity_width", {31'h0, err_parity}, 32'h0);
      n_frame += int'(err_frame);
      n_over  += int'(err_overrun);
      n_par   += int'(err_parity);
      n_valid += int'(tvalid);
      if (tvalid && tready) begin
        n_beat++;
        if (exp_q.size() == 0) check("beat_unexpected", 32'h0, 32'h1);
        else check("beat_data", {24'h0, tdata}, {24'h0, exp_q.pop_front()});
      end
      p_tvalid = tvalid; p_tready = tready; p_tdata = tdata;
      p_ef = err_frame; p_eo = err_overrun; p_ep = err_parity;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    idle(DIV);
  endtask

  // Caller is positioned 1 time unit after a rising edge
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
    fall_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`else
    if (par_flip) rx = 1'b1;
`endif
    send_bit(stop_b);
    rx = 1'b1;
  endtask

  initial begin
    int b0, f0, o0, p0, v0;
    arst = 1'b1; rx = 1'b1; tready = 1'b0;
    idle(3);
    check("rst_tvalid", {31'h0, tvalid}, 32'h0);
    check("rst_tdata", {24'h0, tdata}, 32'h0);
    check("rst_errs", {29'h0, err_frame, err_overrun, err_parity}, 32'h0);
    arst = 1'b0;
    idle(3);

    // Single frame 0xA5: latency and one-cycle tvalid
    tready = 1'b1;
    exp_q.push_back(8'hA5);
    b0 = n_beat; f0 = n_frame; o0 = n_over; p0 = n_par; v0 = n_valid;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(5);
    check("a5_latency", rise_cyc - fall_cyc, 98);
    check("a5_beats", n_beat - b0, 1);
    check("a5_valid_cycles", n_valid - v0, 1);
    check("a5_errs", (n_frame - f0) + (n_over - o0) + (n_par - p0), 0);

    // Vector table
    vecs.push_back('{8'h3C, 1'b0, 1'b0, 1'b0, 1, 0});
    vecs.push_back('{8'h3C, 1'b1, 1'b0, 1'b1, 0, 0});
    vecs.push_back('{8'h81, 1'b1, 1'b0, 1'b1, 0, 0});
    vecs.push_back('{8'h5A, 1'b1, 1'b0, 1'b1, 0, 0});
    vecs.push_back('{8'h01, 1'b1, 1'b0, 1'b1, 0, 0});
    vecs.push_back('{8'h80, 1'b1, 1'b0, 1'b1, 0, 0});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b0, 1'b1, 0, 0});
    vecs.push_back('{8'h07, 1'b1, 1'b1, 1'b0, 0, 1});
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].exp_beat) exp_q.push_back(vecs[i].data);
      b0 = n_beat; f0 = n_frame; o0 = n_over; p0 = n_par;
      send_frame(vecs[i].data, vecs[i].stop_b, vecs[i].par_flip);
      idle(2 * DIV);
      check("vec_beats", n_beat - b0, int'(vecs[i].exp_beat));
      check("vec_frame", n_frame - f0, vecs[i].exp_frame);
      check("vec_parity", n_par - p0, vecs[i].exp_par);
      check("vec_overrun", n_over - o0, 0);
      check("vec_pending", exp_q.size(), 0);
    end

    // Back-to-back frames with no idle gap
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h55);
    b0 = n_beat; f0 = n_frame; o0 = n_over; p0 = n_par;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    idle(2 * DIV);
    check("b2b_beats", n_beat - b0, 3);
    check("b2b_errs", (n_frame - f0) + (n_over - o0) + (n_par - p0), 0);
    check("b2b_pending", exp_q.size(), 0);

    // Overrun while the held byte is not accepted
    tready = 1'b0;
    exp_q.push_back(8'h11);
    b0 = n_beat; o0 = n_over;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    idle(2 * DIV);
    check("ovr_pulses", n_over - o0, 1);
    check("ovr_tvalid", {31'h0, tvalid}, 32'h1);
    check("ovr_tdata", {24'h0, tdata}, 32'h11);
    tready = 1'b1;
    idle(5);
    check("ovr_drain_beats", n_beat - b0, 1);
    check("ovr_drain_tvalid", {31'h0, tvalid}, 32'h0);
    check("ovr_pending", exp_q.size(), 0);

    // Completion coinciding with a handshake on the held byte
    tready = 1'b0;
    exp_q.push_back(8'h44); exp_q.push_back(8'h66);
    b0 = n_beat; o0 = n_over;
    send_frame(8'h44, 1'b1, 1'b0);
    idle(2 * DIV);
    fork
      send_frame(8'h66, 1'b1, 1'b0);
      begin
        idle(97);
        tready = 1'b1;
      end
    join
    idle(2 * DIV);
    check("sim_beats", n_beat - b0, 2);
    check("sim_overrun", n_over - o0, 0);
    check("sim_pending", exp_q.size(), 0);

    // Short low glitch on idle line, then a normal frame
    b0 = n_beat; f0 = n_frame; o0 = n_over; p0 = n_par;
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(3 * DIV);
    check("glitch_beats", n_beat - b0, 0);
    check("glitch_errs", (n_frame - f0) + (n_over - o0) + (n_par - p0), 0);
    check("glitch_tvalid", {31'h0, tvalid}, 32'h0);
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1, 1'b0);
    idle(2 * DIV);
    check("glitch_next_beats", n_beat - b0, 1);

    // Reset in the middle of the data bits of 0x77
    b0 = n_beat; f0 = n_frame; o0 = n_over; p0 = n_par;
    fork
      send_frame(8'h77, 1'b1, 1'b0);
      begin
        idle(40);
        arst = 1'b1;
        idle(2);
        check("mid_rst_tvalid", {31'h0, tvalid}, 32'h0);
        check("mid_rst_tdata", {24'h0, tdata}, 32'h0);
        check("mid_rst_errs", {29'h0, err_frame, err_overrun, err_parity}, 32'h0);
      end
    join
    idle(2);
    arst = 1'b0;
    idle(3 * DIV);
    check("mid_rst_beats", n_beat - b0, 0);
    check("mid_rst_err_cnt", (n_frame - f0) + (n_over - o0) + (n_par - p0), 0);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0);
    idle(2 * DIV);
    check("post_rst_beats", n_beat - b0, 1);
    check("final_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
